// File: rtl/display_pkg.sv
// Shared definitions for the game display path.
// Holds the active-low 7-segment glyphs, the game-state encodings used by
// the controller, the digit-slot layout of the 10-digit display, and
// the score/BCD widths.
package display_pkg;

  // Controller state encodings. Codes 6..15 are unused by the controller.
  typedef enum logic [3:0] {
    ST_LOGGEDOUT = 4'd0,
    ST_WAIT      = 4'd1,
    ST_START     = 4'd2,
    ST_PLAY      = 4'd3,
    ST_JUMP      = 4'd4,
    ST_END       = 4'd5
  } game_state_e;

  // Segment bit positions inside SegN (a = bit 0 ... g = bit 6).
  localparam int SEG_A = 0;
  localparam int SEG_D = 3;
  localparam int SEG_E = 4;
  localparam int SEG_F = 5;

  // Active-low glyphs: a 0 bit lights the segment.
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'h3F;

  // Digit slots: 0..5 playfield columns, 6..9 score thousands..ones.
  localparam int          NUM_DIGITS    = 10;
  localparam logic [3:0]  PLAYER_COL    = 4'd4;
  localparam logic [3:0]  SCORE_BASE    = 4'd6;
  localparam logic [3:0]  DIG_THOUSANDS = 4'd6;
  localparam logic [3:0]  DIG_HUNDREDS  = 4'd7;
  localparam logic [3:0]  DIG_TENS      = 4'd8;
  localparam logic [3:0]  DIG_ONES      = 4'd9;

  localparam int               SCORE_W   = 14;
  localparam int               BCD_W     = 16;
  localparam logic [SCORE_W-1:0] SCORE_MAX = 14'd9999;

  // Decimal digit to active-low glyph; anything above 9 shows blank.
  function automatic logic [6:0] digit_glyph(input logic [3:0] d);
    case (d)
      4'd0:    digit_glyph = 7'h40;
      4'd1:    digit_glyph = 7'h79;
      4'd2:    digit_glyph = 7'h24;
      4'd3:    digit_glyph = 7'h30;
      4'd4:    digit_glyph = 7'h19;
      4'd5:    digit_glyph = 7'h12;
      4'd6:    digit_glyph = 7'h02;
      4'd7:    digit_glyph = 7'h78;
      4'd8:    digit_glyph = 7'h00;
      4'd9:    digit_glyph = 7'h10;
      default: digit_glyph = SEG_BLANK;
    endcase
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter.
// A start pulse while idle loads the operand; 14 shift iterations follow,
// then one cycle with done high while bcd holds the result.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   start       launch request (ignored while busy)
//   bin         14-bit binary operand, sampled on launch
//   busy        high from launch until the done cycle ends
//   done        one-cycle strobe; bcd is valid during it
//   bcd         16-bit packed BCD result (4 digits)
module bin2bcd_seq
  import display_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [SCORE_W-1:0] bin,
  output logic               busy,
  output logic               done,
  output logic [BCD_W-1:0]   bcd
);

  typedef enum logic [1:0] {CV_IDLE, CV_SHIFT, CV_WRITE} cv_state_e;

  localparam logic [3:0] ITER_LAST = 4'(SCORE_W - 1);

  cv_state_e          state_q, state_d;
  logic [SCORE_W-1:0] bin_q, bin_d;
  logic [BCD_W-1:0]   work_q, work_d;
  logic [BCD_W-1:0]   adj;
  logic [3:0]         iter_q, iter_d;

  // Add 3 to every BCD digit that is 5 or more before the shift.
  always_comb begin
    adj = work_q;
    for (int k = 0; k < BCD_W / 4; k++) begin
      if (work_q[4*k +: 4] >= 4'd5) adj[4*k +: 4] = work_q[4*k +: 4] + 4'd3;
    end
  end

  // NOTE: every variable gets a default before the case so no path leaves
  // one unassigned; an unassigned path would infer a latch.
  always_comb begin
    state_d = state_q;
    bin_d   = bin_q;
    work_d  = work_q;
    iter_d  = iter_q;
    case (state_q)
      CV_IDLE: begin
        if (start) begin
          bin_d   = bin;
          work_d  = '0;
          iter_d  = '0;
          state_d = CV_SHIFT;
        end
      end
      CV_SHIFT: begin
        {work_d, bin_d} = {adj, bin_q} << 1;
        iter_d          = iter_q + 4'd1;
        if (iter_q == ITER_LAST) state_d = CV_WRITE;
      end
      CV_WRITE: state_d = CV_IDLE;
      default:  state_d = CV_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= CV_IDLE;
      bin_q   <= '0;
      work_q  <= '0;
      iter_q  <= '0;
    end else begin
      state_q <= state_d;
      bin_q   <= bin_d;
      work_q  <= work_d;
      iter_q  <= iter_d;
    end
  end

  assign busy = (state_q != CV_IDLE);
  assign done = (state_q == CV_WRITE);
  assign bcd  = work_q;

endmodule

// File: rtl/game_display_driver.sv
// Drives a 10-digit multiplexed common-anode 7-segment display from the
// game controller outputs: 6 playfield columns then 4 score digits.
// Ports:
//   Clk, Rst     clock, asynchronous active-low reset
//   GameState    controller state (see game_state_e)
//   FloorBits    floor present per column
//   CeilingBits  ceiling present per column
//   PlayerPos    0 = player on floor, 1 = on ceiling (live, not frame-latched)
//   GameScore    binary score, saturated to 9999 for display
//   SegN         active-low segments, a = bit 0
//   AnodeN       active-low one-hot digit enable
//   FrameStart   one-cycle pulse when the scan index returns to 0
module game_display_driver
  import display_pkg::*;
#(
  parameter int SCAN_DIV     = 1000,
  parameter int BLINK_FRAMES = 25
) (
  input  logic         Clk,
  input  logic         Rst,
  input  logic [3:0]   GameState,
  input  logic [5:0]   FloorBits,
  input  logic [5:0]   CeilingBits,
  input  logic         PlayerPos,
  input  logic [13:0]  GameScore,
  output logic [6:0]   SegN,
  output logic [9:0]   AnodeN,
  output logic         FrameStart
);

  localparam int                SLOT_W     = $clog2(SCAN_DIV);
  localparam logic [SLOT_W-1:0] SLOT_LAST  = SLOT_W'(SCAN_DIV - 1);
  localparam int                BLINK_W    = $clog2(BLINK_FRAMES + 1);
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_FRAMES - 1);
  localparam logic [3:0]        LAST_DIGIT = 4'(NUM_DIGITS - 1);

  // Scan position
  logic [SLOT_W-1:0] slot_q, slot_d;
  logic [3:0]        digit_q, digit_d;
  logic              slot_wrap, frame_wrap;

  // Frame-latched copies of the controller outputs
  logic [5:0] floor_q, floor_d;
  logic [5:0] ceil_q, ceil_d;
  logic [3:0] gstate_q, gstate_d;

  // END-state blink
  logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
  logic               blink_phase_q, blink_phase_d;

  // Score conversion
  logic [SCORE_W-1:0] score_sat, last_score_q;
  logic [BCD_W-1:0]   bcd_value, conv_bcd;
  logic               conv_start, conv_busy, conv_done;
  logic               th_zero, hu_zero, te_zero;

  logic [6:0] seg_d;
  logic [2:0] col;

  assign score_sat  = (GameScore > SCORE_MAX) ? SCORE_MAX : GameScore;
  assign conv_start = !conv_busy && (score_sat != last_score_q);

  bin2bcd_seq u_bin2bcd (
    .clk   (Clk),
    .rst_n (Rst),
    .start (conv_start),
    .bin   (score_sat),
    .busy  (conv_busy),
    .done  (conv_done),
    .bcd   (conv_bcd)
  );

  // Next scan position plus the values the frame latch will hold after this
  // edge; the render uses these so digit 0 of a new frame already sees them.
  always_comb begin
    slot_wrap  = (slot_q == SLOT_LAST);
    frame_wrap = slot_wrap && (digit_q == LAST_DIGIT);
    slot_d     = slot_wrap ? '0 : slot_q + 1'b1;
    digit_d    = digit_q;
    if (slot_wrap) digit_d = frame_wrap ? 4'd0 : digit_q + 4'd1;

    floor_d       = floor_q;
    ceil_d        = ceil_q;
    gstate_d      = gstate_q;
    blink_cnt_d   = blink_cnt_q;
    blink_phase_d = blink_phase_q;
    if (frame_wrap) begin
      floor_d  = FloorBits;
      ceil_d   = CeilingBits;
      gstate_d = GameState;
      // The first END frame starts the count; leaving END clears the phase.
      if (GameState == ST_END && gstate_q == ST_END) begin
        if (blink_cnt_q == BLINK_LAST) begin
          blink_cnt_d   = '0;
          blink_phase_d = ~blink_phase_q;
        end else begin
          blink_cnt_d = blink_cnt_q + 1'b1;
        end
      end else begin
        blink_cnt_d   = '0;
        blink_phase_d = 1'b0;
      end
    end
  end

  // Glyph for the digit slot about to start.
  always_comb begin
    th_zero = (bcd_value[15:12] == 4'd0);
    hu_zero = th_zero && (bcd_value[11:8] == 4'd0);
    te_zero = hu_zero && (bcd_value[7:4] == 4'd0);
    col     = digit_d[2:0];
    seg_d   = SEG_BLANK;
    case (gstate_d)
      ST_WAIT, ST_START, ST_PLAY, ST_JUMP, ST_END: begin
        if (gstate_d == ST_END && blink_phase_d) begin
          seg_d = SEG_BLANK;
        end else if (digit_d < SCORE_BASE) begin
          seg_d[SEG_A] = ~ceil_d[col];
          seg_d[SEG_D] = ~floor_d[col];
          if (digit_d == PLAYER_COL) begin
            if (PlayerPos) seg_d[SEG_F] = 1'b0;
            else           seg_d[SEG_E] = 1'b0;
          end
        end else begin
          case (digit_d)
            DIG_THOUSANDS: seg_d = th_zero ? SEG_BLANK : digit_glyph(bcd_value[15:12]);
            DIG_HUNDREDS:  seg_d = hu_zero ? SEG_BLANK : digit_glyph(bcd_value[11:8]);
            DIG_TENS:      seg_d = te_zero ? SEG_BLANK : digit_glyph(bcd_value[7:4]);
            default:       seg_d = digit_glyph(bcd_value[3:0]);
          endcase
        end
      end
      default: seg_d = SEG_DASH;  // LOGGEDOUT and undefined codes
    endcase
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      slot_q        <= '0;
      digit_q       <= '0;
      floor_q       <= '0;
      ceil_q        <= '0;
      gstate_q      <= '0;
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
      last_score_q  <= '0;
      bcd_value     <= '0;
      SegN          <= SEG_BLANK;
      AnodeN        <= '1;
      FrameStart    <= 1'b0;
    end else begin
      slot_q        <= slot_d;
      digit_q       <= digit_d;
      floor_q       <= floor_d;
      ceil_q        <= ceil_d;
      gstate_q      <= gstate_d;
      blink_cnt_q   <= blink_cnt_d;
      blink_phase_q <= blink_phase_d;
      FrameStart    <= frame_wrap;
      if (conv_start) last_score_q <= score_sat;
      if (conv_done)  bcd_value    <= conv_bcd;
      // Segments change only as a slot begins, while all anodes are off,
      // so a digit never shows its neighbour's pattern.
      if (slot_wrap) begin
        SegN   <= seg_d;
        AnodeN <= '1;
      end else begin
        AnodeN <= ~(10'd1 << digit_q);
      end
    end
  end

endmodule
